// File: rtl/serial_rx_deframer.sv
// Oversampling UART-style receive deframer: start bit, DATA_WIDTH bits LSB first, one stop bit.
// Optional RX_MAJORITY_VOTE_EN decides data and stop bits by a 2-of-3 vote around the bit centre.
module serial_rx_deframer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] out_byte,
  output logic                  out_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic                  r_sync1;
  logic                  r_sync2;
  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_bitIdx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_outByte;
  logic                  r_outValid;
  logic                  r_frameErr;

  logic w_rxS;
  logic w_bitSample;

  // Two-flop synchroniser; reset to the idle (high) line level so release never looks like a start bit.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxS = r_sync2;

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] r_hist;

  // r_hist holds rx_s from the two cycles before the centre sample, so the vote lands at the usual time.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_hist <= 2'b11;
    end else begin
      r_hist <= {r_hist[0], w_rxS};
    end
  end

  assign w_bitSample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxS) | (r_hist[0] & w_rxS);
`else
  assign w_bitSample = w_rxS;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_outByte  <= '0;
      r_outValid <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      r_frameErr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rxS) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          // A start bit must still be low at its centre, otherwise it was a line glitch.
          if (r_cnt == CNT_HALF) begin
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_state  <= w_rxS ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt    <= '0;
            r_shift  <= {w_bitSample, r_shift[DATA_WIDTH-1:1]};
            r_bitIdx <= r_bitIdx + 1'b1;
            if (r_bitIdx == IDX_LAST) begin
              r_state <= S_STOP;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (w_bitSample) begin
              r_outByte  <= r_shift;
              r_outValid <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_frameErr <= 1'b1;
              r_state    <= S_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          // Hold off until the line returns high so a break does not produce a stream of frames.
          r_cnt <= '0;
          if (w_rxS) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_byte  = r_outByte;
  assign out_valid = r_outValid;
  assign frame_err = r_frameErr;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_rx_deframer.sv
// Self-checking bench for serial_rx_deframer: table of frames plus hand-written corner sequences.
// Expected results are queued when a frame is driven and compared when a strobe appears.
module tb_serial_rx_deframer;

  localparam int DW   = 8;
  localparam int CPB  = 16;
  localparam int NVEC = 8;

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [DW-1:0] EXP_CENTRE_GLITCH = 8'hA7;
`else
  localparam logic [DW-1:0] EXP_CENTRE_GLITCH = 8'hA3;
`endif

  logic          clk   = 1'b0;
  logic          arst  = 1'b1;
  logic          rx_in = 1'b1;
  logic [DW-1:0] out_byte;
  logic          out_valid;
  logic          frame_err;
  logic          busy;

  serial_rx_deframer #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .rx_in    (rx_in),
    .out_byte (out_byte),
    .out_valid(out_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          isErr;
    logic [DW-1:0] data;
  } sbEntry_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          stopBit;
    int            holdLow;
    int            gapAfter;
    int            glitchBit;
    int            glitchOff;
    logic          expErr;
    logic [DW-1:0] expByte;
  } vec_t;

  sbEntry_t sbQ[$];
  sbEntry_t monE;
  vec_t     vecs[NVEC];
  int       checks = 0;
  int       failures = 0;
  logic     pendingBusy = 1'b0;
  logic     expBusy = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic driveCycles(input logic v, input int n);
    rx_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bit b occupies cycles CPB*(b+1)..; the DUT's cnt==CPB-1 sample sees the cycle at offset CPB/2.
  task automatic applyStimulus(input vec_t v);
    sbEntry_t e;
    int waitCnt;
    e.isErr = v.expErr;
    e.data  = v.expByte;
    sbQ.push_back(e);
    driveCycles(1'b0, CPB);
    for (int b = 0; b < DW; b++) begin
      if (b == v.glitchBit) begin
        driveCycles(v.data[b], v.glitchOff);
        driveCycles(~v.data[b], 1);
        driveCycles(v.data[b], CPB - v.glitchOff - 1);
      end else begin
        driveCycles(v.data[b], CPB);
      end
    end
    if (v.stopBit) begin
      driveCycles(1'b1, CPB);
    end else begin
      driveCycles(1'b0, CPB + v.holdLow);
      checkOutput("busy_during_break", {31'd0, busy}, 32'd1);
      rx_in = 1'b1;
      waitCnt = 0;
      while (busy && waitCnt < 8) begin
        @(posedge clk);
        #1;
        waitCnt++;
      end
      checkOutput("busy_after_break_release", {31'd0, busy}, 32'd0);
    end
    if (v.gapAfter > 0) begin
      driveCycles(1'b1, v.gapAfter);
    end
  endtask

  // Strobe monitor: pops the scoreboard on every out_valid/frame_err and checks busy one cycle later.
  always @(negedge clk) begin
    if (pendingBusy) begin
      pendingBusy = 1'b0;
      checkOutput("busy_after_strobe", {31'd0, busy}, {31'd0, expBusy});
    end
    if (!arst && (out_valid || frame_err)) begin
      checks++;
      if (sbQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_strobe actual valid=%0b err=%0b byte=%0h required no strobe",
                 out_valid, frame_err, out_byte);
      end else begin
        monE = sbQ.pop_front();
        if ((out_valid && frame_err) || (frame_err !== monE.isErr) || (out_byte !== monE.data)) begin
          failures++;
          $display("[TB] FAIL frame_result actual valid=%0b err=%0b byte=%0h required err=%0b byte=%0h",
                   out_valid, frame_err, out_byte, monE.isErr, monE.data);
        end
        pendingBusy = 1'b1;
        expBusy     = frame_err;
      end
    end
  end

  initial begin
    int busyCount;
    int waitCnt;

    vecs[0] = '{8'hA7, 1'b1, 0,  20, -1, 0,           1'b0, 8'hA7};
    vecs[1] = '{8'h3C, 1'b0, 40, 10, -1, 0,           1'b1, 8'hA7};
    vecs[2] = '{8'h01, 1'b1, 0,  0,  -1, 0,           1'b0, 8'h01};
    vecs[3] = '{8'hFE, 1'b1, 0,  20, -1, 0,           1'b0, 8'hFE};
    vecs[4] = '{8'hA7, 1'b1, 0,  20, 2,  CPB / 2 - 1, 1'b0, 8'hA7};
    vecs[5] = '{8'hA7, 1'b1, 0,  20, 2,  CPB / 2,     1'b0, EXP_CENTRE_GLITCH};
    vecs[6] = '{8'h00, 1'b1, 0,  0,  -1, 0,           1'b0, 8'h00};
    vecs[7] = '{8'hFF, 1'b1, 0,  20, -1, 0,           1'b0, 8'hFF};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_byte", {24'd0, out_byte}, 32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    arst = 1'b0;
    driveCycles(1'b1, 10);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
    end

    // Short low pulse: start check at mid-bit rejects it without any strobe.
    driveCycles(1'b0, 4);
    rx_in = 1'b1;
    busyCount = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (busy) busyCount++;
    end
    checks++;
    if (busyCount < 1 || busyCount > 9) begin
      failures++;
      $display("[TB] FAIL short_glitch_busy actual=%0d cycles required 1..9", busyCount);
    end
    checkOutput("short_glitch_idle", {31'd0, busy}, 32'd0);

    // Abort a 0x55 frame in the middle of bit 4 with reset.
    driveCycles(1'b0, CPB);
    for (int b = 0; b < 4; b++) begin
      driveCycles(b[0] ? 1'b0 : 1'b1, CPB);
    end
    driveCycles(1'b1, CPB / 2);
    arst = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midframe_reset_out_byte", {24'd0, out_byte}, 32'd0);
    checkOutput("midframe_reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midframe_reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("midframe_reset_busy", {31'd0, busy}, 32'd0);
    arst = 1'b0;
    driveCycles(1'b1, 3 * CPB);
    checkOutput("after_reset_idle", {31'd0, busy}, 32'd0);
    applyStimulus('{8'h55, 1'b1, 0, 20, -1, 0, 1'b0, 8'h55});

    waitCnt = 0;
    while (sbQ.size() != 0 && waitCnt < 400) begin
      @(posedge clk);
      #1;
      waitCnt++;
    end
    checkOutput("scoreboard_drained", sbQ.size(), 32'd0);
    driveCycles(1'b1, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
